mac_accumulator: RTL and testbench
==================================

# mac_accumulator

Accumulates a frame of `LEN` consecutive unsigned products from the pipelined `multiplier` into one dot-product result. It sits directly downstream of `multiplier` and consumes its `pdt` output qualified by a valid strobe. The finished sum is presented on a valid/ready output port. An optional saturation stage clamps the result to the product width.

## Interface
- `WIDTH`, 40: multiplier operand width; products are `2*WIDTH` bits.
- `LEN`, 16: products per frame; legal range is 1 to 1024.
- `ACC_WIDTH`, `2*WIDTH + $clog2(LEN) + 1`: internal accumulator width. It cannot overflow within a frame.

- `clk_in`  in  1  system clock; all logic is on the rising edge.
- `rst_in`  in  1  synchronous, active-high reset.
- `start_in`  in  1  begin a new frame; honoured only in IDLE.
- `pdt_in`  in  `2*WIDTH`  unsigned product from `multiplier`.
- `pdt_valid_in`  in  1  `pdt_in` is valid this cycle.
- `result_out`  out  `2*WIDTH`  frame sum.
- `result_valid_out`  out  1  `result_out` is valid.
- `result_ready_in`  in  1  consumer accepts the result.
- `overflow_out`  out  1  frame sum exceeded `2^(2*WIDTH)-1`; qualified by `result_valid_out`.
- `busy_out`  out  1  high in ACCUM or DONE.

## Operation
- Three-state FSM: IDLE, ACCUM, DONE.
- IDLE:
  - `busy_out` is 0.
  - `pdt_valid_in` is ignored.
  - `start_in` clears the accumulator, the product counter and the overflow flag, then goes to ACCUM.
- ACCUM:
  - Every cycle with `pdt_valid_in=1` accepts one product.
  - Accepted products go into a one-deep input register (`pdt_q`, `vld_q`). The register adds into `acc` on the following edge, zero-extended to `ACC_WIDTH`.
  - The counter increments per accepted product.
  - After the `LEN`th product is accepted, further `pdt_valid_in` is ignored.
  - Once the `LEN`th product has been added, go to DONE.
- DONE:
  - `result_valid_out=1`. `result_out` and `overflow_out` are held stable until `result_ready_in=1`.
  - On the handshake edge, return to IDLE.
  - `start_in` is ignored in ACCUM and DONE, including during the handshake cycle.
- Gaps: `pdt_valid_in` may deassert for any number of cycles mid-frame. Accumulation simply pauses.
- Result arithmetic:
  - `overflow_out = |acc[ACC_WIDTH-1:2*WIDTH]`.
  - `result_out` follows the Configuration section.
- Reset:
  - `rst_in` in any state returns to IDLE, discarding any partial sum.
  - All outputs are 0 after reset: `result_out=0`, `result_valid_out=0`, `overflow_out=0`, `busy_out=0`.
  - The accumulator, counter and input register are cleared.

## Timing
- `start_in` sampled at edge s: `busy_out=1` from edge s onward.
- The earliest product accepted is the one sampled at edge s+1. A product sampled at edge s is dropped.
- Product sampled at edge t is in `acc` after edge t+1.
- `LEN`th product sampled at edge t: `result_valid_out` rises after edge t+2.
- Minimum frame latency, `start_in` to `result_valid_out`, is `LEN+3` edges.
- `result_ready_in` is held high at rise: IDLE is reached after the next edge, and `result_valid_out` is valid for exactly one cycle.
- `result_ready_in` asserted in IDLE or ACCUM has no effect.
- `LEN=1`: the single product is sampled at edge t; DONE is reached after edge t+2.

## Configuration
- `MAC_SATURATE_EN` defined:
  - `result_out` is `2^(2*WIDTH)-1` (all ones) when `overflow_out=1`.
  - Otherwise it is `acc[2*WIDTH-1:0]`.
- `MAC_SATURATE_EN` undefined: `result_out = acc[2*WIDTH-1:0]` (wrap-around).
- `overflow_out` is reported identically in both builds.

## Test plan
- LEN=4, start, then products 2, 12, 30, 56 on consecutive cycles, ready held high:
  - `result_out=100`, `overflow_out=0`.
  - `result_valid_out` is high for exactly 1 cycle, 6 edges after the first product.
- LEN=4, products 2, 12, 30, 56 with 3 idle cycles between each:
  - `result_out=100`.
  - `busy_out` stays high throughout.
- LEN=2, products `2^80-1` and 5:
  - With `MAC_SATURATE_EN`: `result_out=2^80-1`, `overflow_out=1`.
  - Without it: `result_out=4`, `overflow_out=1`.
- LEN=4, 4 products given, ready held low for 10 cycles while 3 more valid products and a `start_in` arrive:
  - `result_out` stays 100 and `result_valid_out` stays high.
  - The extra products and the start are ignored.
  - IDLE is reached after ready rises.
- `rst_in` after 2 of 4 products (2, 12):
  - All outputs are 0 next cycle.
  - A new frame of 1, 1, 1, 1 gives `result_out=4`.
- Products with `pdt_valid_in` high while in IDLE, before start:
  - Ignored; the following frame of 2, 12, 30, 56 gives 100.

Source files
------------

// File: rtl/mac_accumulator.sv
// mac_accumulator: sums a frame of LEN unsigned products into one result on a valid/ready port.
// Define MAC_SATURATE_EN to clamp result_out to all ones when the frame sum overflows 2*WIDTH bits.
module mac_accumulator #(
  parameter int unsigned WIDTH     = 40,
  parameter int unsigned LEN       = 16,
  parameter int unsigned ACC_WIDTH = 2*WIDTH + $clog2(LEN) + 1
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 start_in,
  input  logic [2*WIDTH-1:0]   pdt_in,
  input  logic                 pdt_valid_in,
  output logic [2*WIDTH-1:0]   result_out,
  output logic                 result_valid_out,
  input  logic                 result_ready_in,
  output logic                 overflow_out,
  output logic                 busy_out
);

  localparam int unsigned PW = 2*WIDTH;
  localparam int unsigned CW = $clog2(LEN + 1);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t               state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [PW-1:0]        pdt_q, pdt_d;
  logic                 vld_q, vld_d;

  logic                 frame_full;
  logic                 accept;

  assign frame_full = (cnt_q == CW'(LEN));
  assign accept     = (state_q == ACCUM) && pdt_valid_in && !frame_full;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    pdt_d   = pdt_q;
    vld_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_in) begin
          acc_d   = '0;
          cnt_d   = '0;
          pdt_d   = '0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (vld_q) begin
          acc_d = acc_q + ACC_WIDTH'(pdt_q);
        end
        if (accept) begin
          pdt_d = pdt_in;
          vld_d = 1'b1;
          cnt_d = cnt_q + CW'(1);
        end
        // Leave only once the last accepted product has drained out of the input register.
        if (frame_full && !vld_q) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (result_ready_in) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      pdt_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      pdt_q   <= pdt_d;
      vld_q   <= vld_d;
    end
  end

  assign overflow_out     = |acc_q[ACC_WIDTH-1:PW];
  assign result_valid_out = (state_q == DONE);
  assign busy_out         = (state_q != IDLE);

`ifdef MAC_SATURATE_EN
  assign result_out = overflow_out ? '1 : acc_q[PW-1:0];
`else
  assign result_out = acc_q[PW-1:0];
`endif

endmodule

// File: tb/tb_mac_accumulator.sv
// Self-checking bench for mac_accumulator: table vectors, hand sequences and random frames
// checked against a plain-arithmetic frame-sum model.
module tb_mac_accumulator;

  localparam int unsigned W  = 40;
  localparam int unsigned PW = 2*W;

  typedef logic [3:0][PW-1:0] frame_t;

  typedef struct packed {
    frame_t        p;
    logic [7:0]    gap;
    logic [7:0]    rwait;
    logic          noise;
    logic [PW-1:0] exp_res;
    logic          exp_ovf;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          start4, pv4, ready4, rv4, ovf4, busy4;
  logic [PW-1:0] pdt4, res4;
  logic          start2, pv2, ready2, rv2, ovf2, busy2;
  logic [PW-1:0] pdt2, res2;

  int errors = 0;
  int checks = 0;

  mac_accumulator #(.WIDTH(W), .LEN(4)) u_dut4 (
    .clk_in(clk), .rst_in(rst), .start_in(start4), .pdt_in(pdt4),
    .pdt_valid_in(pv4), .result_out(res4), .result_valid_out(rv4),
    .result_ready_in(ready4), .overflow_out(ovf4), .busy_out(busy4)
  );

  mac_accumulator #(.WIDTH(W), .LEN(2)) u_dut2 (
    .clk_in(clk), .rst_in(rst), .start_in(start2), .pdt_in(pdt2),
    .pdt_valid_in(pv2), .result_out(res2), .result_valid_out(rv2),
    .result_ready_in(ready2), .overflow_out(ovf2), .busy_out(busy2)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [PW-1:0] rand_pdt();
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    if ($urandom_range(0, 2) == 0) return r[PW-1:0];
    return PW'(r[15:0]);
  endfunction

  // Reference: the frame sum as an exact integer, then wrap or clamp to PW bits.
  function automatic logic [127:0] model_sum(input frame_t p);
    logic [127:0] s;
    s = '0;
    for (int i = 0; i < 4; i++) s = s + 128'(p[i]);
    return s;
  endfunction

  function automatic logic [PW-1:0] model_result(input logic [127:0] s);
`ifdef MAC_SATURATE_EN
    if ((s >> PW) != 0) return '1;
`endif
    return s[PW-1:0];
  endfunction

  // Entered just after a negedge with the LEN=4 DUT idle.
  task automatic run_frame4(input vec_t v, input string tag);
    ready4 = (v.rwait == 0);
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    check({tag, " busy_after_start"}, busy4, 1'b1);
    for (int i = 0; i < 4; i++) begin
      for (int g = 0; g < int'(v.gap); g++) begin
        pv4 = 1'b0;
        @(negedge clk);
        check({tag, " busy_in_gap"}, busy4, 1'b1);
      end
      pdt4 = v.p[i];
      pv4  = 1'b1;
      @(negedge clk);
      pv4  = 1'b0;
      check({tag, " no_early_valid"}, rv4, 1'b0);
    end
    pv4  = v.noise;
    pdt4 = rand_pdt();
    @(negedge clk);
    check({tag, " valid_low_t1"}, rv4, 1'b0);
    @(negedge clk);
    pv4 = 1'b0;
    check({tag, " valid_rise_t2"}, rv4, 1'b1);
    check({tag, " result"}, res4, v.exp_res);
    check({tag, " overflow"}, ovf4, v.exp_ovf);
    for (int k = 0; k < int'(v.rwait); k++) begin
      pv4    = v.noise && (k < 3);
      pdt4   = rand_pdt();
      start4 = v.noise && (k == 5 || k == int'(v.rwait) - 1);
      @(negedge clk);
      check({tag, " valid_held"}, rv4, 1'b1);
      check({tag, " result_held"}, res4, v.exp_res);
    end
    pv4    = v.noise;
    start4 = v.noise;
    ready4 = 1'b1;
    @(negedge clk);
    ready4 = 1'b0;
    pv4    = 1'b0;
    start4 = 1'b0;
    check({tag, " valid_one_cycle"}, rv4, 1'b0);
    check({tag, " idle_after_handshake"}, busy4, 1'b0);
    @(negedge clk);
    check({tag, " still_idle"}, busy4, 1'b0);
  endtask

  vec_t vecs[5];

  initial begin
    vec_t   v;
    logic [127:0] s;

    vecs[0] = '{p: {PW'(56), PW'(30), PW'(12), PW'(2)}, gap: 0, rwait: 0, noise: 0,
                exp_res: PW'(100), exp_ovf: 0};
    vecs[1] = '{p: {PW'(56), PW'(30), PW'(12), PW'(2)}, gap: 3, rwait: 0, noise: 0,
                exp_res: PW'(100), exp_ovf: 0};
    vecs[2] = '{p: {PW'(56), PW'(30), PW'(12), PW'(2)}, gap: 0, rwait: 10, noise: 1,
                exp_res: PW'(100), exp_ovf: 0};
    vecs[3] = '{p: {PW'(0), PW'(0), PW'(1), {PW{1'b1}}}, gap: 1, rwait: 2, noise: 0,
`ifdef MAC_SATURATE_EN
                exp_res: {PW{1'b1}}, exp_ovf: 1};
`else
                exp_res: PW'(0), exp_ovf: 1};
`endif
    vecs[4] = '{p: {PW'(7), PW'(0), PW'(0), PW'(9)}, gap: 2, rwait: 1, noise: 1,
                exp_res: PW'(16), exp_ovf: 0};

    rst = 1'b1;
    start4 = 0; pv4 = 0; ready4 = 0; pdt4 = '0;
    start2 = 0; pv2 = 0; ready2 = 0; pdt2 = '0;
    repeat (3) @(negedge clk);
    check("reset result", res4, '0);
    check("reset valid", rv4, 1'b0);
    check("reset overflow", ovf4, 1'b0);
    check("reset busy", busy4, 1'b0);
    check("reset2 result", res2, '0);
    check("reset2 busy", busy2, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      run_frame4(vecs[i], $sformatf("vec%0d", i));
    end

    // Products offered in IDLE must not leak into the next frame.
    for (int k = 0; k < 4; k++) begin
      pdt4 = PW'(1000 + k);
      pv4  = 1'b1;
      @(negedge clk);
      check("idle_noise busy", busy4, 1'b0);
      check("idle_noise valid", rv4, 1'b0);
    end
    pv4 = 1'b0;
    run_frame4(vecs[0], "after_idle_noise");

    // Reset mid-frame with one product summed and one in the input register.
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    pdt4 = PW'(2); pv4 = 1'b1;
    @(negedge clk);
    pdt4 = PW'(12);
    @(negedge clk);
    pv4 = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midreset result", res4, '0);
    check("midreset valid", rv4, 1'b0);
    check("midreset overflow", ovf4, 1'b0);
    check("midreset busy", busy4, 1'b0);
    v = '{p: {PW'(1), PW'(1), PW'(1), PW'(1)}, gap: 0, rwait: 0, noise: 0,
          exp_res: PW'(4), exp_ovf: 0};
    run_frame4(v, "after_reset");

    // LEN=2 overflow frame.
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    pdt2 = {PW{1'b1}}; pv2 = 1'b1;
    @(negedge clk);
    pdt2 = PW'(5);
    @(negedge clk);
    pv2 = 1'b0;
    check("len2 valid_low_t0", rv2, 1'b0);
    @(negedge clk);
    check("len2 valid_low_t1", rv2, 1'b0);
    @(negedge clk);
    check("len2 valid_rise", rv2, 1'b1);
    check("len2 overflow", ovf2, 1'b1);
`ifdef MAC_SATURATE_EN
    check("len2 result", res2, {PW{1'b1}});
`else
    check("len2 result", res2, PW'(4));
`endif
    ready2 = 1'b1;
    @(negedge clk);
    ready2 = 1'b0;
    check("len2 handshake", rv2, 1'b0);
    check("len2 idle", busy2, 1'b0);

    // Random frames against the arithmetic model.
    for (int n = 0; n < 30; n++) begin
      for (int i = 0; i < 4; i++) v.p[i] = rand_pdt();
      if ($urandom_range(0, 5) == 0) v.p[0] = {PW{1'b1}};
      v.gap   = 8'($urandom_range(0, 2));
      v.rwait = 8'($urandom_range(0, 4));
      v.noise = 1'($urandom_range(0, 1));
      s = model_sum(v.p);
      v.exp_res = model_result(s);
      v.exp_ovf = ((s >> PW) != 0);
      run_frame4(v, $sformatf("rand%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
